// File: rtl/mcpu_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control path.
package mcpu_pkg;

    localparam int unsigned OP_W      = 6;
    localparam int unsigned FN_W      = 6;
    localparam int unsigned ALU_OP_W  = 3;
    localparam int unsigned SEL_W     = 2;
    localparam int unsigned REG_IDX_W = 5;

    // Link register written by jal when reg_dst selects RA.
    localparam logic [REG_IDX_W-1:0] RA_REG = 5'd31;

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EXE  = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd5
    } state_t;

    // Opcodes (IR[31:26])
    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
    localparam logic [OP_W-1:0] OP_HALT  = 6'h3F;

    // R-type function codes (IR[5:0])
    localparam logic [FN_W-1:0] FN_SLL = 6'h00;
    localparam logic [FN_W-1:0] FN_ADD = 6'h20;
    localparam logic [FN_W-1:0] FN_SUB = 6'h22;
    localparam logic [FN_W-1:0] FN_AND = 6'h24;
    localparam logic [FN_W-1:0] FN_OR  = 6'h25;
    localparam logic [FN_W-1:0] FN_SLT = 6'h2A;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4,
        ALU_SLL = 3'd5
    } alu_op_t;

    typedef enum logic [3:0] {
        CLS_RTYPE   = 4'd0,
        CLS_IARITH  = 4'd1,
        CLS_LOAD    = 4'd2,
        CLS_STORE   = 4'd3,
        CLS_BRANCH  = 4'd4,
        CLS_JUMP    = 4'd5,
        CLS_JAL     = 4'd6,
        CLS_HALT    = 4'd7,
        CLS_ILLEGAL = 4'd8
    } instr_class_t;

    localparam logic [SEL_W-1:0] PC_SRC_SEQ    = 2'd0;
    localparam logic [SEL_W-1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [SEL_W-1:0] PC_SRC_JUMP   = 2'd2;

    localparam logic [SEL_W-1:0] REG_DST_RT = 2'd0;
    localparam logic [SEL_W-1:0] REG_DST_RD = 2'd1;
    localparam logic [SEL_W-1:0] REG_DST_RA = 2'd2;

    localparam logic [SEL_W-1:0] WB_SEL_ALU = 2'd0;
    localparam logic [SEL_W-1:0] WB_SEL_MEM = 2'd1;
    localparam logic [SEL_W-1:0] WB_SEL_PC4 = 2'd2;

    // Decoded view of the current instruction.
    typedef struct packed {
        instr_class_t cls;
        logic         ext_sel;
        alu_op_t      alu_op;
        logic         use_shamt;
        logic         use_imm;
        logic         branch_ne;
    } decode_t;

endpackage

// File: rtl/mcpu_decode.sv
// Combinational opcode/funct decoder: instruction class plus operand controls.
module mcpu_decode
    import mcpu_pkg::*;
#(
    parameter logic [OP_W-1:0] HALT_OP = OP_HALT
) (
    input  logic [OP_W-1:0] opcode,
    input  logic [FN_W-1:0] funct,
    output decode_t         dec
);

    // Map opcode/funct to class, extender mode and ALU operation.
    always_comb begin
        dec        = '0;
        dec.cls    = CLS_ILLEGAL;
        dec.alu_op = ALU_ADD;
        if (opcode == HALT_OP) begin
            dec.cls = CLS_HALT;
        end else begin
            case (opcode)
                OP_RTYPE: begin
                    dec.cls = CLS_RTYPE;
                    case (funct)
                        FN_ADD:  dec.alu_op = ALU_ADD;
                        FN_SUB:  dec.alu_op = ALU_SUB;
                        FN_AND:  dec.alu_op = ALU_AND;
                        FN_OR:   dec.alu_op = ALU_OR;
                        FN_SLT:  dec.alu_op = ALU_SLT;
                        FN_SLL: begin
                            dec.alu_op    = ALU_SLL;
                            dec.use_shamt = 1'b1;
                        end
                        default: dec.cls = CLS_ILLEGAL;
                    endcase
                end
                OP_ADDI: begin
                    dec.cls     = CLS_IARITH;
                    dec.ext_sel = 1'b1;
                    dec.use_imm = 1'b1;
                    dec.alu_op  = ALU_ADD;
                end
                OP_SLTI: begin
                    dec.cls     = CLS_IARITH;
                    dec.ext_sel = 1'b1;
                    dec.use_imm = 1'b1;
                    dec.alu_op  = ALU_SLT;
                end
                OP_ANDI: begin
                    dec.cls     = CLS_IARITH;
                    dec.use_imm = 1'b1;
                    dec.alu_op  = ALU_AND;
                end
                OP_ORI: begin
                    dec.cls     = CLS_IARITH;
                    dec.use_imm = 1'b1;
                    dec.alu_op  = ALU_OR;
                end
                OP_LW: begin
                    dec.cls     = CLS_LOAD;
                    dec.ext_sel = 1'b1;
                    dec.use_imm = 1'b1;
                end
                OP_SW: begin
                    dec.cls     = CLS_STORE;
                    dec.ext_sel = 1'b1;
                    dec.use_imm = 1'b1;
                end
                OP_BEQ: begin
                    dec.cls     = CLS_BRANCH;
                    dec.ext_sel = 1'b1;
                    dec.alu_op  = ALU_SUB;
                end
                OP_BNE: begin
                    dec.cls       = CLS_BRANCH;
                    dec.ext_sel   = 1'b1;
                    dec.alu_op    = ALU_SUB;
                    dec.branch_ne = 1'b1;
                end
                OP_J:    dec.cls = CLS_JUMP;
                OP_JAL:  dec.cls = CLS_JAL;
                default: dec.cls = CLS_ILLEGAL;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: IF/ID/EXE/MEM/WB walk with per-state datapath controls.
module multicycle_ctrl
    import mcpu_pkg::*;
#(
    parameter logic [OP_W-1:0] HALT_OP = OP_HALT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OP_W-1:0]     opcode,
    input  logic [FN_W-1:0]     funct,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                pc_wr,
    output logic [SEL_W-1:0]    pc_src,
    output logic                ir_wr,
    output logic                ext_sel,
    output logic                alu_src_a,
    output logic                alu_src_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                reg_wr,
    output logic [SEL_W-1:0]    reg_dst,
    output logic [SEL_W-1:0]    wb_sel,
    output logic                mem_rd,
    output logic                mem_wr,
    output logic                illegal,
    output logic                halted,
    output logic [2:0]          state
);

    state_t  state_q;
    state_t  state_d;
    decode_t dec;
    logic    taken;

    mcpu_decode #(
        .HALT_OP (HALT_OP)
    ) u_decode (
        .opcode (opcode),
        .funct  (funct),
        .dec    (dec)
    );

    assign state = state_q;

    // State register; reset always returns to fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IF;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath controls; everything idles while reset is high.
    always_comb begin
        state_d   = state_q;
        pc_wr     = 1'b0;
        pc_src    = PC_SRC_SEQ;
        ir_wr     = 1'b0;
        ext_sel   = 1'b0;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        alu_op    = ALU_OP_W'(ALU_ADD);
        reg_wr    = 1'b0;
        reg_dst   = REG_DST_RT;
        wb_sel    = WB_SEL_ALU;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        illegal   = 1'b0;
        halted    = 1'b0;
        taken     = dec.branch_ne ? !zero : zero;

        if (!reset) begin
            // Operand controls stay stable from decode until the instruction retires.
            if (state_q inside {ST_ID, ST_EXE, ST_MEM, ST_WB}) begin
                ext_sel   = dec.ext_sel;
                alu_src_a = dec.use_shamt;
                alu_src_b = dec.use_imm;
                alu_op    = ALU_OP_W'(dec.alu_op);
            end

            case (state_q)
                ST_IF: begin
                    ir_wr   = 1'b1;
                    state_d = ST_ID;
                end
                ST_ID: begin
                    case (dec.cls)
                        CLS_JUMP: begin
                            pc_wr   = 1'b1;
                            pc_src  = PC_SRC_JUMP;
                            state_d = ST_IF;
                        end
                        CLS_JAL: begin
                            pc_wr   = 1'b1;
                            pc_src  = PC_SRC_JUMP;
                            reg_wr  = 1'b1;
                            reg_dst = REG_DST_RA;
                            wb_sel  = WB_SEL_PC4;
                            state_d = ST_IF;
                        end
                        CLS_HALT: state_d = ST_HALT;
                        CLS_ILLEGAL: begin
                            illegal = 1'b1;
                            pc_wr   = 1'b1;
                            state_d = ST_IF;
                        end
                        default: state_d = ST_EXE;
                    endcase
                end
                ST_EXE: begin
                    case (dec.cls)
                        CLS_BRANCH: begin
                            pc_wr   = 1'b1;
                            pc_src  = taken ? PC_SRC_BRANCH : PC_SRC_SEQ;
                            state_d = ST_IF;
                        end
                        CLS_LOAD, CLS_STORE: state_d = ST_MEM;
                        default:             state_d = ST_WB;
                    endcase
                end
                ST_MEM: begin
                    if (dec.cls == CLS_LOAD) begin
                        mem_rd = 1'b1;
                        if (mem_ready) begin
                            state_d = ST_WB;
                        end
                    end else begin
                        mem_wr = 1'b1;
                        if (mem_ready) begin
                            pc_wr   = 1'b1;
                            state_d = ST_IF;
                        end
                    end
                end
                ST_WB: begin
                    reg_wr  = 1'b1;
                    pc_wr   = 1'b1;
                    reg_dst = (dec.cls == CLS_RTYPE) ? REG_DST_RD : REG_DST_RT;
                    wb_sel  = (dec.cls == CLS_LOAD) ? WB_SEL_MEM : WB_SEL_ALU;
                    state_d = ST_IF;
                end
                ST_HALT: halted = 1'b1;
                default: state_d = ST_IF;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for the multi-cycle control sequencer.
module tb_multicycle_ctrl;

    localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_EXE = 3'd2,
                           S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5;
    localparam logic [2:0] A_ADD = 3'd0, A_SUB = 3'd1, A_AND = 3'd2,
                           A_OR = 3'd3, A_SLT = 3'd4, A_SLL = 3'd5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_wr, ir_wr, ext_sel, alu_src_a, alu_src_b, reg_wr;
    logic       mem_rd, mem_wr, illegal, halted;
    logic [1:0] pc_src, reg_dst, wb_sel;
    logic [2:0] alu_op, state;

    int errors = 0;
    int checks = 0;

    multicycle_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .funct     (funct),
        .zero      (zero),
        .mem_ready (mem_ready),
        .pc_wr     (pc_wr),
        .pc_src    (pc_src),
        .ir_wr     (ir_wr),
        .ext_sel   (ext_sel),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .alu_op    (alu_op),
        .reg_wr    (reg_wr),
        .reg_dst   (reg_dst),
        .wb_sel    (wb_sel),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .illegal   (illegal),
        .halted    (halted),
        .state     (state)
    );

    always #5 clk = ~clk;

    // Full observed control word and the enable-only subset checked during reset.
    logic [21:0] obs;
    logic [6:0]  enables;
    assign obs = {state, pc_wr, pc_src, ir_wr, ext_sel, alu_src_a, alu_src_b, alu_op,
                  reg_wr, reg_dst, wb_sel, mem_rd, mem_wr, illegal, halted};
    assign enables = {pc_wr, ir_wr, reg_wr, mem_rd, mem_wr, illegal, halted};

    function automatic logic [21:0] ev(input logic [2:0] st, input logic pcw,
                                       input logic [1:0] pcs, input logic irw, ext, asa, asb,
                                       input logic [2:0] aop, input logic rw,
                                       input logic [1:0] rd, wb,
                                       input logic mr, mw, ill, hlt);
        return {st, pcw, pcs, irw, ext, asa, asb, aop, rw, rd, wb, mr, mw, ill, hlt};
    endfunction

    function automatic logic [21:0] v_if();
        return ev(S_IF, 0, 0, 1, 0, 0, 0, A_ADD, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step();
            reset = 1'b1;
            #3;
            checks++;
            if (enables !== 7'd0 || state !== S_IF) begin
                errors++;
                $display("FAIL reset cycle %0d: state=%0d enables=%b expected state=0 enables=0000000",
                         i, state, enables);
            end
        end
    endtask

    task automatic test_add();
        logic [21:0] exp_q[$];
        exp_q.push_back(v_if());
        exp_q.push_back(ev(S_ID,  0, 0, 0, 0, 0, 0, A_ADD, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(ev(S_EXE, 0, 0, 0, 0, 0, 0, A_ADD, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(ev(S_WB,  1, 0, 0, 0, 0, 0, A_ADD, 1, 1, 0, 0, 0, 0, 0));
        foreach (exp_q[i]) begin
            step();
            reset = 1'b0; opcode = 6'h00; funct = 6'h20; zero = 1'b0; mem_ready = 1'b0;
            #3;
            checks++;
            if (obs !== exp_q[i]) begin
                errors++;
                $display("FAIL add cycle %0d: got %h expected %h", i, obs, exp_q[i]);
            end
        end
    endtask

    task automatic test_rtype_alu();
        logic [5:0]  fns[3] = '{6'h00, 6'h2A, 6'h22};
        logic [2:0]  aops[3] = '{A_SLL, A_SLT, A_SUB};
        logic        shs[3] = '{1'b1, 1'b0, 1'b0};
        logic [21:0] e;
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < 4; i++) begin
                step();
                reset = 1'b0; opcode = 6'h00; funct = fns[n]; mem_ready = 1'b1;
                case (i)
                    0:       e = v_if();
                    1:       e = ev(S_ID,  0, 0, 0, 0, shs[n], 0, aops[n], 0, 0, 0, 0, 0, 0, 0);
                    2:       e = ev(S_EXE, 0, 0, 0, 0, shs[n], 0, aops[n], 0, 0, 0, 0, 0, 0, 0);
                    default: e = ev(S_WB,  1, 0, 0, 0, shs[n], 0, aops[n], 1, 1, 0, 0, 0, 0, 0);
                endcase
                #3;
                checks++;
                if (obs !== e) begin
                    errors++;
                    $display("FAIL rtype funct %h cycle %0d: got %h expected %h", fns[n], i, obs, e);
                end
            end
        end
    endtask

    task automatic test_ext_sel();
        logic [5:0]  ops[4] = '{6'h0D, 6'h08, 6'h0C, 6'h0A};
        logic        exts[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0]  aops[4] = '{A_OR, A_ADD, A_AND, A_SLT};
        logic [21:0] e;
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 4; i++) begin
                step();
                reset = 1'b0; opcode = ops[n]; funct = 6'h3F; mem_ready = 1'b0;
                case (i)
                    0:       e = v_if();
                    1:       e = ev(S_ID,  0, 0, 0, exts[n], 0, 1, aops[n], 0, 0, 0, 0, 0, 0, 0);
                    2:       e = ev(S_EXE, 0, 0, 0, exts[n], 0, 1, aops[n], 0, 0, 0, 0, 0, 0, 0);
                    default: e = ev(S_WB,  1, 0, 0, exts[n], 0, 1, aops[n], 1, 0, 0, 0, 0, 0, 0);
                endcase
                #3;
                checks++;
                if (obs !== e) begin
                    errors++;
                    $display("FAIL itype op %h cycle %0d: got %h expected %h", ops[n], i, obs, e);
                end
            end
        end
    endtask

    task automatic test_load_wait();
        logic [21:0] e;
        for (int i = 0; i < 8; i++) begin
            step();
            reset = 1'b0; opcode = 6'h23; funct = 6'h00;
            mem_ready = (i == 6);
            case (i)
                0:          e = v_if();
                1:          e = ev(S_ID,  0, 0, 0, 1, 0, 1, A_ADD, 0, 0, 0, 0, 0, 0, 0);
                2:          e = ev(S_EXE, 0, 0, 0, 1, 0, 1, A_ADD, 0, 0, 0, 0, 0, 0, 0);
                3, 4, 5, 6: e = ev(S_MEM, 0, 0, 0, 1, 0, 1, A_ADD, 0, 0, 0, 1, 0, 0, 0);
                default:    e = ev(S_WB,  1, 0, 0, 1, 0, 1, A_ADD, 1, 0, 1, 0, 0, 0, 0);
            endcase
            #3;
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL lw cycle %0d: got %h expected %h", i, obs, e);
            end
        end
    endtask

    task automatic test_store();
        logic [21:0] exp_q[$];
        exp_q.push_back(v_if());
        exp_q.push_back(ev(S_ID,  0, 0, 0, 1, 0, 1, A_ADD, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(ev(S_EXE, 0, 0, 0, 1, 0, 1, A_ADD, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(ev(S_MEM, 1, 0, 0, 1, 0, 1, A_ADD, 0, 0, 0, 0, 1, 0, 0));
        foreach (exp_q[i]) begin
            step();
            reset = 1'b0; opcode = 6'h2B; funct = 6'h00; mem_ready = 1'b1;
            #3;
            checks++;
            if (obs !== exp_q[i]) begin
                errors++;
                $display("FAIL sw cycle %0d: got %h expected %h", i, obs, exp_q[i]);
            end
        end
    endtask

    task automatic test_branch();
        logic [5:0]  ops[4] = '{6'h04, 6'h04, 6'h05, 6'h05};
        logic        zs[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [1:0]  pcs[4] = '{2'd1, 2'd0, 2'd1, 2'd0};
        logic [21:0] e;
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 3; i++) begin
                step();
                reset = 1'b0; opcode = ops[n]; funct = 6'h00; zero = zs[n]; mem_ready = 1'b0;
                case (i)
                    0:       e = v_if();
                    1:       e = ev(S_ID,  0, 0,      0, 1, 0, 0, A_SUB, 0, 0, 0, 0, 0, 0, 0);
                    default: e = ev(S_EXE, 1, pcs[n], 0, 1, 0, 0, A_SUB, 0, 0, 0, 0, 0, 0, 0);
                endcase
                #3;
                checks++;
                if (obs !== e) begin
                    errors++;
                    $display("FAIL branch op %h zero %0d cycle %0d: got %h expected %h",
                             ops[n], zs[n], i, obs, e);
                end
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_jump_illegal();
        logic [5:0]  ops[4] = '{6'h02, 6'h03, 6'h3E, 6'h00};
        logic [5:0]  fns[4] = '{6'h00, 6'h00, 6'h00, 6'h3F};
        logic [21:0] ids[4];
        logic [21:0] e;
        ids[0] = ev(S_ID, 1, 2, 0, 0, 0, 0, A_ADD, 0, 0, 0, 0, 0, 0, 0);
        ids[1] = ev(S_ID, 1, 2, 0, 0, 0, 0, A_ADD, 1, 2, 2, 0, 0, 0, 0);
        ids[2] = ev(S_ID, 1, 0, 0, 0, 0, 0, A_ADD, 0, 0, 0, 0, 0, 1, 0);
        ids[3] = ids[2];
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 2; i++) begin
                step();
                reset = 1'b0; opcode = ops[n]; funct = fns[n]; mem_ready = 1'b0;
                e = (i == 0) ? v_if() : ids[n];
                #3;
                checks++;
                if (obs !== e) begin
                    errors++;
                    $display("FAIL jump/illegal op %h funct %h cycle %0d: got %h expected %h",
                             ops[n], fns[n], i, obs, e);
                end
            end
        end
    endtask

    task automatic test_halt();
        logic [21:0] e;
        for (int i = 0; i < 8; i++) begin
            step();
            reset = 1'b0; opcode = 6'h3F; funct = 6'h00;
            mem_ready = i[0];
            case (i)
                0:       e = v_if();
                1:       e = ev(S_ID,   0, 0, 0, 0, 0, 0, A_ADD, 0, 0, 0, 0, 0, 0, 0);
                default: e = ev(S_HALT, 0, 0, 0, 0, 0, 0, A_ADD, 0, 0, 0, 0, 0, 0, 1);
            endcase
            #3;
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL halt cycle %0d: got %h expected %h", i, obs, e);
            end
        end
        step();
        reset = 1'b1;
        #3;
        checks++;
        if (enables !== 7'd0 || state !== S_HALT) begin
            errors++;
            $display("FAIL halt reset: state=%0d enables=%b expected state=5 enables=0000000",
                     state, enables);
        end
    endtask

    task automatic test_reset_mid_mem();
        logic [21:0] e;
        for (int i = 0; i < 4; i++) begin
            step();
            reset = 1'b0; opcode = 6'h23; funct = 6'h00; mem_ready = 1'b0;
            case (i)
                0:       e = v_if();
                1:       e = ev(S_ID,  0, 0, 0, 1, 0, 1, A_ADD, 0, 0, 0, 0, 0, 0, 0);
                2:       e = ev(S_EXE, 0, 0, 0, 1, 0, 1, A_ADD, 0, 0, 0, 0, 0, 0, 0);
                default: e = ev(S_MEM, 0, 0, 0, 1, 0, 1, A_ADD, 0, 0, 0, 1, 0, 0, 0);
            endcase
            #3;
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL lw pre-reset cycle %0d: got %h expected %h", i, obs, e);
            end
        end
        step();
        reset = 1'b1;
        #3;
        checks++;
        if (enables !== 7'd0 || state !== S_MEM) begin
            errors++;
            $display("FAIL mem reset: state=%0d enables=%b expected state=3 enables=0000000",
                     state, enables);
        end
        step();
        reset = 1'b0;
        #3;
        checks++;
        if (obs !== v_if()) begin
            errors++;
            $display("FAIL after mem reset: got %h expected %h", obs, v_if());
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_rtype_alu();
        test_ext_sel();
        test_load_wait();
        test_store();
        test_branch();
        test_jump_illegal();
        test_halt();
        test_reset_mid_mem();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle sequencer for the MIPS datapath: register file, ALU, sign/zero extender, data memory, PC and IR.
- Walks each instruction through IF/ID/EXE/MEM/WB states.
- Decodes opcode/funct into per-state datapath controls, including the extender's ext_sel.
- Handshakes with data memory through mem_ready.
- Replaces the single-cycle combinational control unit when the CPU moves to multi-cycle operation.

Parameters:
- HALT_OP, 6'b111111, opcode that parks the FSM in HALT.
- RA_REG, 5'd31, link register index; reg_dst=RA selects it.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- opcode  input  6  IR[31:26]; valid from ID onward
- funct  input  6  IR[5:0]
- zero  input  1  ALU zero flag, valid in EXE
- mem_ready  input  1  data memory completes the current rd/wr this cycle
- pc_wr  output  1  PC load enable
- pc_src  output  2  0=PC+4, 1=branch target, 2=jump target
- ir_wr  output  1  IR load enable
- ext_sel  output  1  1=sign extend, 0=zero extend (drives the extender)
- alu_src_a  output  1  0=rs, 1=shamt
- alu_src_b  output  1  0=rt, 1=extended imm
- alu_op  output  3  ADD, SUB, AND, OR, SLT, SLL (package encodings)
- reg_wr  output  1  register file write enable
- reg_dst  output  2  0=rt, 1=rd, 2=RA
- wb_sel  output  2  0=ALU, 1=mem data, 2=PC+4
- mem_rd  output  1  data memory read
- mem_wr  output  1  data memory write
- illegal  output  1  one-cycle pulse in ID on an unknown opcode/funct
- halted  output  1  high while in HALT
- state  output  3  current state, for debug

Behaviour:
- States: IF, ID, EXE, MEM, WB, HALT. Reset loads IF.
- While reset is high, every enable output (pc_wr, ir_wr, reg_wr, mem_rd, mem_wr, illegal) is 0 and halted=0.
- Outputs are combinational from state, opcode, funct, zero and mem_ready.
- Outside the states that use them, pc_src, alu_*, reg_dst and wb_sel default to 0. ext_sel and alu controls are held constant from ID to the end of the instruction.
- ext_sel=1 for addi, slti, lw, sw, beq, bne. ext_sel=0 for andi, ori and all other opcodes.
- Supported instructions: R-type (add, sub, and, or, slt, sll), addi, andi, ori, slti, lw, sw, beq, bne, j, jal, halt.
- IF: ir_wr=1 for one cycle, then ID.
- ID:
  - j: pc_wr=1, pc_src=2, then IF.
  - jal: also reg_wr=1, reg_dst=2, wb_sel=2.
  - halt: go to HALT.
  - Illegal opcode/funct: illegal=1, pc_wr=1, pc_src=0, then IF (executes as a nop).
  - Otherwise go to EXE.
- EXE:
  - sll: alu_src_a=1. I-type arithmetic, lw, sw: alu_src_b=1.
  - beq/bne: alu_op=SUB. pc_wr=1 and pc_src=1 if the branch is taken (beq: zero=1; bne: zero=0), else pc_src=0. Then IF.
  - lw/sw: go to MEM. All others: go to WB.
- MEM: alu_op and alu_src_b stay at their EXE values (lw/sw address computation).
  - lw: mem_rd held high until mem_ready, then WB.
  - sw: mem_wr held high until mem_ready; in the cycle mem_ready=1, pc_wr=1, pc_src=0, then IF.
  - Unlimited wait; mem_ready outside MEM is ignored.
- WB: reg_wr=1 and pc_wr=1 (pc_src=0).
  - lw: wb_sel=1, reg_dst=0.
  - R-type: wb_sel=0, reg_dst=1.
  - I-type: wb_sel=0, reg_dst=0.
  - Then IF.
- HALT: all enables 0 and halted=1. Only reset leaves HALT.
- pc_wr asserts exactly once per instruction, in its final cycle.
- reg_wr and mem_wr never assert in the same cycle.
- Reset mid-MEM drops mem_rd/mem_wr in the same cycle; next state is IF.

Decomposition:
- Package mcpu_pkg holds the state enum, opcode/funct constants, ALU op encodings, and the pc_src/reg_dst/wb_sel encodings.
- One sub-module, mcpu_decode: combinational opcode/funct to class (RTYPE, IARITH, LOAD, STORE, BRANCH, JUMP, JAL, HALT, ILLEGAL) plus ext_sel and alu_op. The FSM lives in multicycle_ctrl.

Test Plan:
- add (op 0, funct 0x20) with mem_ready=0 → states IF,ID,EXE,WB. reg_dst=1 and reg_wr=1 only in WB; pc_wr only in WB; 4 cycles total.
- ori (0x0D) then addi (0x08) → ext_sel=0 for ori and 1 for addi throughout ID..WB; alu_op OR then ADD.
- lw (0x23) with mem_ready delayed 3 cycles → mem_rd high for 4 MEM cycles; then WB with wb_sel=1, reg_wr=1.
- sw (0x2B) with mem_ready=1 immediately → one MEM cycle with mem_wr=1 and pc_wr=1; reg_wr stays 0 all instruction.
- beq (0x04) with zero=1 then zero=0 → pc_src=1 then 0, pc_wr=1 in EXE both times. bne (0x05) with zero=0 → pc_src=1.
- jal (0x03), opcode 0x3E, halt (0x3F), then reset asserted in HALT and mid-lw MEM:
  - jal → reg_dst=2, wb_sel=2, pc_src=2 in ID.
  - 0x3E → illegal pulse, nop.
  - halt → halted=1 held indefinitely.
  - Reset → next state IF; mem_rd=0 in the reset cycle.
